// File: rtl/or_stim_pkg.sv
// Shared constants for the four-channel square-wave stimulus generator.
package or_stim_pkg;

    // Default counter / half-period register width.
    localparam int unsigned CNT_W_DEF = 8;

    // Number of generated channels.
    localparam int unsigned N_CH = 4;

    // Channel select encoding carried on half_sel.
    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2,
        CH_D = 2'd3
    } chan_e;

    // Default half-periods in clk cycles, restored on reset.
    localparam int unsigned HALF_A_DEF = 100;
    localparam int unsigned HALF_B_DEF = 70;
    localparam int unsigned HALF_C_DEF = 50;
    localparam int unsigned HALF_D_DEF = 20;

endpackage

// File: rtl/or_stim_gen_if.sv
// Control and waveform bus of or_stim_gen; the master drives controls and
// observes the four channel waveforms plus the all-zero sync pulse.
interface or_stim_gen_if
    import or_stim_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             en;
    logic             clr;
    logic             load;
    logic [1:0]       half_sel;
    logic [CNT_W-1:0] half_val;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             sync;

    modport master (
        output en, clr, load, half_sel, half_val,
        input  a, b, c, d, sync
    );

    modport slave (
        input  en, clr, load, half_sel, half_val,
        output a, b, c, d, sync
    );

endinterface

// File: rtl/or_stim_chan.sv
// One square-wave channel: half-period register, cycle counter and the
// toggling output. Priority is rst > clr > load > count.
module or_stim_chan
    import or_stim_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned HALF_RST = HALF_A_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] half_val_i,
    output logic             wave_o,
    output logic             wave_d_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] half_d;
    logic [CNT_W-1:0] eff_half;
    logic             wave_q;
    logic             wave_d;

    // Next-state: clr clears counter/output, load restarts the period,
    // otherwise count and toggle at terminal count.
    always_comb begin
        eff_half = (half_q == '0) ? ONE : half_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        wave_d   = wave_q;
        if (clr_i) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (load_i) begin
            // A load restarts the period without toggling, so a shrunk
            // half-period can never leave the counter past its terminal.
            half_d = half_val_i;
            cnt_d  = '0;
        end else if (en_i) begin
            if (cnt_q == eff_half - ONE) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // State registers with synchronous reset to the default half-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            half_q <= CNT_W'(HALF_RST);
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            wave_q <= wave_d;
        end
    end

    assign wave_o   = wave_q;
    assign wave_d_o = wave_d;

endmodule

// File: rtl/or_stim_gen.sv
// Four-channel programmable square-wave generator feeding the a/b/c/d
// inputs of the OR-gate stage, with a pulse when all channels return to 0.
module or_stim_gen
    import or_stim_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned HALF_A = HALF_A_DEF,
    parameter int unsigned HALF_B = HALF_B_DEF,
    parameter int unsigned HALF_C = HALF_C_DEF,
    parameter int unsigned HALF_D = HALF_D_DEF
) (
    input  logic         clk,
    input  logic         rst,
    or_stim_gen_if.slave bus
);

    logic [N_CH-1:0] load_ch;
    logic [N_CH-1:0] wave;
    logic [N_CH-1:0] wave_nxt;
    logic            sync_q;
    logic            sync_d;

    // Route the load strobe only to the channel picked by half_sel.
    always_comb begin
        load_ch = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            load_ch[i] = bus.load && (bus.half_sel == 2'(i));
        end
    end

    or_stim_chan #(
        .CNT_W    (CNT_W),
        .HALF_RST (HALF_A)
    ) u_chan_a (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (bus.clr),
        .en_i       (bus.en),
        .load_i     (load_ch[CH_A]),
        .half_val_i (bus.half_val),
        .wave_o     (wave[CH_A]),
        .wave_d_o   (wave_nxt[CH_A])
    );

    or_stim_chan #(
        .CNT_W    (CNT_W),
        .HALF_RST (HALF_B)
    ) u_chan_b (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (bus.clr),
        .en_i       (bus.en),
        .load_i     (load_ch[CH_B]),
        .half_val_i (bus.half_val),
        .wave_o     (wave[CH_B]),
        .wave_d_o   (wave_nxt[CH_B])
    );

    or_stim_chan #(
        .CNT_W    (CNT_W),
        .HALF_RST (HALF_C)
    ) u_chan_c (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (bus.clr),
        .en_i       (bus.en),
        .load_i     (load_ch[CH_C]),
        .half_val_i (bus.half_val),
        .wave_o     (wave[CH_C]),
        .wave_d_o   (wave_nxt[CH_C])
    );

    or_stim_chan #(
        .CNT_W    (CNT_W),
        .HALF_RST (HALF_D)
    ) u_chan_d (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (bus.clr),
        .en_i       (bus.en),
        .load_i     (load_ch[CH_D]),
        .half_val_i (bus.half_val),
        .wave_o     (wave[CH_D]),
        .wave_d_o   (wave_nxt[CH_D])
    );

    // Sync fires on the edge where the waveforms fall to all-zero through
    // normal counting; a clr forcing zero is deliberately excluded.
    always_comb begin
        sync_d = !bus.clr && bus.en && (wave != '0) && (wave_nxt == '0);
    end

    // Register sync alongside the channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign bus.a    = wave[CH_A];
    assign bus.b    = wave[CH_B];
    assign bus.c    = wave[CH_C];
    assign bus.d    = wave[CH_D];
    assign bus.sync = sync_q;

endmodule

// File: tb/tb_or_stim_gen.sv
// Bench for or_stim_gen: directed scenarios plus random control traffic,
// checked every cycle against an event-time model of the four channels.
module tb_or_stim_gen;

    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    or_stim_gen_if #(.CNT_W(CW)) bus ();

    or_stim_gen #(
        .CNT_W  (CW),
        .HALF_A (100),
        .HALF_B (70),
        .HALF_C (50),
        .HALF_D (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: each channel toggles when the global count of
    // enabled edges reaches its scheduled toggle time.
    int unsigned m_half [4];
    longint      m_next [4];
    logic        m_wave [4];
    logic        m_sync;
    longint      m_e;

    function automatic longint eff(input int unsigned h);
        return (h == 0) ? 64'd1 : longint'(h);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic e,
                              input logic ld, input logic [1:0] sel, input logic [CW-1:0] val);
        logic prev_any;
        logic now_any;
        prev_any = m_wave[0] | m_wave[1] | m_wave[2] | m_wave[3];
        m_sync   = 1'b0;
        if (r) begin
            m_half[0] = 100; m_half[1] = 70; m_half[2] = 50; m_half[3] = 20;
            for (int k = 0; k < 4; k++) begin
                m_wave[k] = 1'b0;
                m_next[k] = m_e + eff(m_half[k]);
            end
        end else if (c) begin
            for (int k = 0; k < 4; k++) begin
                m_wave[k] = 1'b0;
                m_next[k] = m_e + eff(m_half[k]);
            end
        end else begin
            if (e) m_e++;
            for (int k = 0; k < 4; k++) begin
                if (ld && int'(sel) == k) begin
                    m_half[k] = int'(val);
                    m_next[k] = m_e + eff(m_half[k]);
                end else if (e && m_e == m_next[k]) begin
                    m_wave[k] = ~m_wave[k];
                    m_next[k] = m_next[k] + eff(m_half[k]);
                end
            end
            now_any = m_wave[0] | m_wave[1] | m_wave[2] | m_wave[3];
            m_sync  = prev_any && !now_any;
        end
    endtask

    // One clock edge: drive controls, advance model, compare all outputs.
    task automatic tick(input logic r, input logic c, input logic e,
                        input logic ld, input logic [1:0] sel, input logic [CW-1:0] val);
        rst          = r;
        bus.clr      = c;
        bus.en       = e;
        bus.load     = ld;
        bus.half_sel = sel;
        bus.half_val = val;
        @(posedge clk);
        model_step(r, c, e, ld, sel, val);
        #1;
        check_eq("outs_abcd_sync",
                 {27'd0, bus.a, bus.b, bus.c, bus.d, bus.sync},
                 {27'd0, m_wave[0], m_wave[1], m_wave[2], m_wave[3], m_sync});
        @(negedge clk);
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, '0);
    endtask

    initial begin
        m_e = 0;
        for (int k = 0; k < 4; k++) begin
            m_half[k] = 0;
            m_next[k] = 0;
            m_wave[k] = 1'b0;
        end
        m_sync = 1'b0;

        // Reset, then free-running defaults.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        check_eq("rst_outs", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'd0);
        check_eq("rst_sync", {31'd0, bus.sync}, 32'd0);
        for (int i = 1; i <= 100; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, '0);
            if (i < 20) check_eq("no_sync_early", {31'd0, bus.sync}, 32'd0);
            if (i == 19) check_eq("d_low_19", {31'd0, bus.d}, 32'd0);
            if (i == 20) check_eq("d_rise_20", {31'd0, bus.d}, 32'd1);
            if (i == 39) check_eq("d_high_39", {31'd0, bus.d}, 32'd1);
            if (i == 40) check_eq("d_fall_40", {31'd0, bus.d}, 32'd0);
            if (i == 40) check_eq("sync_40", {31'd0, bus.sync}, 32'd1);
            if (i == 41) check_eq("sync_41", {31'd0, bus.sync}, 32'd0);
            if (i == 49) check_eq("c_low_49", {31'd0, bus.c}, 32'd0);
            if (i == 50) check_eq("c_rise_50", {31'd0, bus.c}, 32'd1);
            if (i == 70) check_eq("b_rise_70", {31'd0, bus.b}, 32'd1);
            if (i == 99) check_eq("a_low_99", {31'd0, bus.a}, 32'd0);
            if (i == 100) check_eq("a_rise_100", {31'd0, bus.a}, 32'd1);
        end

        // Freeze: en low for 10 cycles starting after edge 30.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        for (int i = 1; i <= 55; i++) begin
            tick(1'b0, 1'b0, !(i > 30 && i <= 40), 1'b0, 2'd0, '0);
            if (i == 40) check_eq("frz_d_40", {31'd0, bus.d}, 32'd1);
            if (i == 49) check_eq("frz_d_49", {31'd0, bus.d}, 32'd1);
            if (i == 50) check_eq("frz_d_fall_50", {31'd0, bus.d}, 32'd0);
        end

        // Load d=5 at edge 12.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        for (int i = 1; i <= 30; i++) begin
            tick(1'b0, 1'b0, 1'b1, (i == 12), 2'd3, 8'd5);
            if (i == 16) check_eq("ld_d_16", {31'd0, bus.d}, 32'd0);
            if (i == 17) check_eq("ld_d_rise_17", {31'd0, bus.d}, 32'd1);
            if (i == 21) check_eq("ld_d_21", {31'd0, bus.d}, 32'd1);
            if (i == 22) check_eq("ld_d_fall_22", {31'd0, bus.d}, 32'd0);
        end

        // Half-period 0 on c, then clr overriding a simultaneous load.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 8'd0);
        check_eq("ld0_c_hold", {31'd0, bus.c}, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, '0);
            check_eq("half0_c_toggle", {31'd0, bus.c}, 32'(i % 2));
        end
        run_en(25);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'd9);
        check_eq("clr_outs", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'd0);
        check_eq("clr_sync", {31'd0, bus.sync}, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, '0);
        check_eq("clr_kept_half_c", {31'd0, bus.c}, 32'd1);

        // Reset mid-run while a and b are high.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        run_en(110);
        check_eq("ab_high", {30'd0, bus.a, bus.b}, 32'd3);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, '0);
        check_eq("mid_rst_outs", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'd0);
        check_eq("mid_rst_sync", {31'd0, bus.sync}, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, '0);
            if (i == 20) check_eq("rst_half_d_20", {31'd0, bus.d}, 32'd1);
        end

        // Random control traffic.
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom % 700) == 0,
                 ($urandom % 90) == 0,
                 ($urandom_range(0, 9)) != 0,
                 ($urandom % 10) == 0,
                 2'($urandom_range(0, 3)),
                 CW'($urandom_range(0, 12)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
